// File: rtl/noc_pkg.sv
// Shared definitions for the 3x3 mesh NoC: flit layout, mesh geometry and router
// port numbering. Used by the router, the packet injector and the ejector.
package noc_pkg;

    localparam int FLIT_W   = 34;
    localparam int HEAD_BIT = 33;
    localparam int TAIL_BIT = 32;

    localparam int SRC_HI = 31;
    localparam int SRC_LO = 28;
    localparam int DST_HI = 27;
    localparam int DST_LO = 24;
    localparam int LEN_HI = 23;
    localparam int LEN_LO = 16;

    localparam int MESH_X = 3;
    localparam int MESH_Y = 3;

    localparam int CORE      = 0;
    localparam int E         = 1;
    localparam int N         = 2;
    localparam int W         = 3;
    localparam int S         = 4;
    localparam int NUM_PORTS = 5;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        INJ_IDLE = 2'd0,
        INJ_HEAD = 2'd1,
        INJ_BODY = 2'd2,
        INJ_DONE = 2'd3
    } inj_state_e;

    function automatic logic [1:0] node_x(input logic [3:0] id);
        return 2'(int'(id) % MESH_X);
    endfunction

    function automatic logic [1:0] node_y(input logic [3:0] id);
        return 2'(int'(id) / MESH_X);
    endfunction

    function automatic flit_t make_head(input logic [3:0] src,
                                        input logic [3:0] dst,
                                        input logic [7:0] len8,
                                        input logic       last);
        flit_t f;
        f                = '0;
        f[HEAD_BIT]      = 1'b1;
        f[TAIL_BIT]      = last;
        f[SRC_HI:SRC_LO] = src;
        f[DST_HI:DST_LO] = dst;
        f[LEN_HI:LEN_LO] = len8;
        return f;
    endfunction

    function automatic flit_t make_body(input logic last, input logic [31:0] data);
        return {1'b0, last, data};
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic show-ahead synchronous FIFO; o_data always presents the oldest entry.
// A push is accepted while full when a pop happens in the same cycle.
module noc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data    = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/noc_packet_injector.sv
// Core-side NoC transmitter: turns a (dst, len) command plus buffered payload words
// into a head/body/tail wormhole packet on a router Core port using req/ack.
module noc_packet_injector
    import noc_pkg::*;
#(
    parameter int ID         = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_data,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_req,
    input  logic              in_ack,
    output logic              busy,
    output logic              pkt_done,
    output logic [15:0]       pkt_count
);

    localparam logic [3:0] SRC_ID = 4'(ID);
    localparam int         LEN8_W = (LEN_W < 8) ? LEN_W : 8;

    inj_state_e        r_state;
    inj_state_e        w_state_nxt;
    logic [FLIT_W-1:0] r_flit;
    logic              r_req;
    logic              r_pkt_done;
    logic [15:0]       r_pkt_count;
    logic [LEN_W-1:0]  r_remaining;

    logic [7:0]        w_len8;
    logic              w_xfer;
    logic              w_enter_done;
    logic              w_last_word;
    logic              w_load_head;
    logic              w_load_word;
    logic              w_drop_req;
    logic              w_push;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [31:0]       w_fifo_data;

    assign w_push = wr_valid & ~w_fifo_full;

    noc_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (wr_data),
        .i_pop   (w_load_word),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // r_remaining counts words not yet loaded into r_flit, so the word loaded
    // while it equals one is the tail.
    assign w_xfer       = r_req & in_ack;
    assign w_enter_done = w_xfer & r_flit[TAIL_BIT];
    assign w_last_word  = (r_remaining == LEN_W'(1));

    always_comb begin
        w_len8             = '0;
        w_len8[LEN8_W-1:0] = cmd_len[LEN8_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= INJ_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INJ_IDLE: if (cmd_valid)    w_state_nxt = INJ_HEAD;
            INJ_HEAD: if (w_xfer)       w_state_nxt = r_flit[TAIL_BIT] ? INJ_DONE : INJ_BODY;
            INJ_BODY: if (w_enter_done) w_state_nxt = INJ_DONE;
            INJ_DONE:                   w_state_nxt = INJ_IDLE;
            default:                    w_state_nxt = INJ_IDLE;
        endcase
    end

    // A non-tail transfer reloads from the FIFO in the same cycle when a word is
    // waiting, which keeps back-to-back flits bubble-free.
    always_comb begin
        w_load_head = 1'b0;
        w_load_word = 1'b0;
        w_drop_req  = 1'b0;
        case (r_state)
            INJ_IDLE: w_load_head = cmd_valid;
            INJ_HEAD, INJ_BODY: begin
                if (w_xfer) begin
                    if (r_flit[TAIL_BIT] || w_fifo_empty) w_drop_req  = 1'b1;
                    else                                  w_load_word = 1'b1;
                end else if (!r_req && !w_fifo_empty) begin
                    w_load_word = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit      <= '0;
            r_req       <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_pkt_done <= w_enter_done;
            if (w_enter_done) r_pkt_count <= r_pkt_count + 16'd1;
            if (w_load_head) begin
                r_flit <= make_head(SRC_ID, cmd_dst, w_len8, cmd_len == '0);
                r_req  <= 1'b1;
            end else if (w_load_word) begin
                r_flit <= make_body(w_last_word, w_fifo_data);
                r_req  <= 1'b1;
            end else if (w_drop_req) begin
                r_req  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_head)      r_remaining <= cmd_len;
        else if (w_load_word) r_remaining <= r_remaining - LEN_W'(1);
    end

    assign out_flit  = r_flit;
    assign out_req   = r_req;
    assign pkt_done  = r_pkt_done;
    assign pkt_count = r_pkt_count;
    assign cmd_ready = (r_state == INJ_IDLE);
    assign busy      = (r_state != INJ_IDLE);
    assign wr_ready  = ~w_fifo_full;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Randomized bench for noc_packet_injector: a queue model of accepted payload words
// predicts every packet's flits, which are compared with what the router side saw.
module tb_noc_packet_injector;

    localparam int ID         = 0;
    localparam int FIFO_DEPTH = 8;
    localparam int LEN_W      = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_dst;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    logic [33:0]      out_flit;
    logic             out_req;
    logic             in_ack;
    logic             busy;
    logic             pkt_done;
    logic [15:0]      pkt_count;

    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];
    logic [31:0] model_q[$];
    int n_vec     = 0;
    int n_err     = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    noc_packet_injector #(
        .ID         (ID),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .out_flit  (out_flit),
        .out_req   (out_req),
        .in_ack    (in_ack),
        .busy      (busy),
        .pkt_done  (pkt_done),
        .pkt_count (pkt_count)
    );

    // Router side: record every flit that actually transfers.
    always @(posedge clk) begin
        if (rst === 1'b0 && out_req === 1'b1 && in_ack === 1'b1) got_q.push_back(out_flit);
    end

    // Advance one cycle; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        if (wr_valid && wr_ready && !rst) model_q.push_back(wr_data);
        @(negedge clk);
    endtask

    function automatic logic [33:0] head_flit(input int dst, input int len);
        logic [33:0] f;
        f = 34'h2_0000_0000 | (34'(ID) << 28) | (34'(dst) << 24) | (34'(len % 256) << 16);
        if (len == 0) f = f | 34'h1_0000_0000;
        return f;
    endfunction

    function automatic logic [33:0] body_flit(input logic [31:0] d, input bit last);
        return {1'b0, last, d};
    endfunction

    task automatic expect_packet(input int dst, input int len);
        exp_q.delete();
        exp_q.push_back(head_flit(dst, len));
        for (int i = 0; i < len; i++) begin
            if (model_q.size() > 0) exp_q.push_back(body_flit(model_q.pop_front(), i == len - 1));
            else                    exp_q.push_back('x);
        end
    endtask

    task automatic test_reset();
        n_vec++; if (out_req !== 1'b0)     begin n_err++; $display("FAIL rst_out_req: got %b, expected 0", out_req); end
        n_vec++; if (out_flit !== 34'h0)   begin n_err++; $display("FAIL rst_out_flit: got %h, expected 0", out_flit); end
        n_vec++; if (pkt_count !== 16'h0)  begin n_err++; $display("FAIL rst_pkt_count: got %0d, expected 0", pkt_count); end
        n_vec++; if (pkt_done !== 1'b0)    begin n_err++; $display("FAIL rst_pkt_done: got %b, expected 0", pkt_done); end
        n_vec++; if (cmd_ready !== 1'b1)   begin n_err++; $display("FAIL rst_cmd_ready: got %b, expected 1", cmd_ready); end
        n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        n_vec++; if (wr_ready !== 1'b1)    begin n_err++; $display("FAIL rst_wr_ready: got %b, expected 1", wr_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        in_ack = 1'b1;
        cmd_valid = 1'b1; cmd_dst = 4'd4; cmd_len = 8'd0;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_cmd_ready: got %b, expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (out_req !== 1'b1)           begin n_err++; $display("FAIL single_req: got %b, expected 1", out_req); end
        n_vec++; if (out_flit !== 34'h3_0400_0000) begin n_err++; $display("FAIL single_flit: got %h, expected 304000000", out_flit); end
        tick();
        exp_count++;
        n_vec++; if (out_req !== 1'b0)  begin n_err++; $display("FAIL single_req_drop: got %b, expected 0", out_req); end
        n_vec++; if (pkt_done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b, expected 1", pkt_done); end
        n_vec++; if (pkt_count !== 16'(exp_count)) begin n_err++; $display("FAIL single_count: got %0d, expected %0d", pkt_count, exp_count); end
        tick();
        n_vec++; if (pkt_done !== 1'b0)  begin n_err++; $display("FAIL single_done_pulse: got %b, expected 0", pkt_done); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b, expected 1", cmd_ready); end
    endtask

    task automatic test_len2();
        wr_valid = 1'b1; wr_data = 32'hAAAA_0001; tick();
        wr_data = 32'hAAAA_0002; tick();
        wr_valid = 1'b0; in_ack = 1'b1;
        cmd_valid = 1'b1; cmd_dst = 4'd4; cmd_len = 8'd2;
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (out_flit !== 34'h2_0402_0000) begin n_err++; $display("FAIL len2_head: got %h, expected 204020000", out_flit); end
        tick();
        n_vec++; if (out_flit !== 34'h0_AAAA_0001 || out_req !== 1'b1) begin n_err++; $display("FAIL len2_body: got %h req %b, expected 0aaaa0001 req 1", out_flit, out_req); end
        tick();
        n_vec++; if (out_flit !== 34'h1_AAAA_0002 || out_req !== 1'b1) begin n_err++; $display("FAIL len2_tail: got %h req %b, expected 1aaaa0002 req 1", out_flit, out_req); end
        tick();
        exp_count++;
        n_vec++; if (pkt_done !== 1'b1 || out_req !== 1'b0) begin n_err++; $display("FAIL len2_done: got done %b req %b, expected done 1 req 0", pkt_done, out_req); end
        n_vec++; if (pkt_count !== 16'(exp_count)) begin n_err++; $display("FAIL len2_count: got %0d, expected %0d", pkt_count, exp_count); end
        model_q.delete();
        tick();
    endtask

    task automatic test_backpressure();
        logic [33:0] held;
        int cyc;
        int dst;
        dst = $urandom_range(0, 8);
        wr_valid = 1'b1; wr_data = $urandom; tick();
        wr_data = $urandom; tick();
        wr_valid = 1'b0;
        got_q.delete();
        in_ack = 1'b1;
        cmd_valid = 1'b1; cmd_dst = 4'(dst); cmd_len = 8'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        held = out_flit;
        in_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (out_req !== 1'b1 || out_flit !== held) begin n_err++; $display("FAIL bp_hold[%0d]: got %h req %b, expected %h req 1", i, out_flit, out_req, held); end
        end
        in_ack = 1'b1;
        cyc = 0;
        while (pkt_done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        n_vec++; if (pkt_done !== 1'b1) begin n_err++; $display("FAIL bp_done_timeout: got %b, expected 1", pkt_done); end
        exp_count++;
        expect_packet(dst, 2);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_flit_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_flit[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] w;
        got_q.delete();
        in_ack = 1'b1;
        cmd_valid = 1'b1; cmd_dst = 4'd7; cmd_len = 8'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_vec++; if (out_req !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL starve_wait: got req %b busy %b, expected req 0 busy 1", out_req, busy); end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                tick();
                n_vec++; if (out_req !== 1'b0) begin n_err++; $display("FAIL starve_idle[%0d]: got req %b, expected 0", k, out_req); end
            end
            w = $urandom;
            wr_valid = 1'b1; wr_data = w; tick();
            wr_valid = 1'b0;
            n_vec++; if (out_req !== 1'b0) begin n_err++; $display("FAIL starve_early[%0d]: got req %b, expected 0", k, out_req); end
            tick();
            n_vec++; if (out_req !== 1'b1 || out_flit !== body_flit(w, k == 2)) begin n_err++; $display("FAIL starve_word[%0d]: got %h req %b, expected %h req 1", k, out_flit, out_req, body_flit(w, k == 2)); end
        end
        tick();
        exp_count++;
        n_vec++; if (pkt_done !== 1'b1) begin n_err++; $display("FAIL starve_done: got %b, expected 1", pkt_done); end
        expect_packet(7, 3);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL starve_flit_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        tick();
    endtask

    task automatic test_fifo_full();
        int cyc;
        in_ack = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = $urandom;
            n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_early[%0d]: got %b, expected 1", i, wr_ready); end
            tick();
        end
        wr_data = 32'hDEAD_BEEF;
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b, expected 0", wr_ready); end
        tick();
        got_q.delete();
        in_ack = 1'b1;
        cmd_valid = 1'b1; cmd_dst = 4'd2; cmd_len = 8'(FIFO_DEPTH);
        wr_data = $urandom;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (pkt_done !== 1'b1 && cyc < 60) begin
            wr_valid = (cyc < 5);
            wr_data = $urandom;
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        n_vec++; if (cyc != FIFO_DEPTH + 1) begin n_err++; $display("FAIL full_throughput: got %0d cycles, expected %0d", cyc, FIFO_DEPTH + 1); end
        exp_count++;
        expect_packet(2, FIFO_DEPTH);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL full_flit_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_flit[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_random();
        for (int p = 0; p < 16; p++) begin
            int          dst;
            int          len;
            int          cyc;
            logic        prev_req;
            logic        prev_ack;
            logic [33:0] prev_flit;
            dst = $urandom_range(0, 8);
            len = $urandom_range(0, 6);
            got_q.delete();
            n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rnd_cmd_ready[%0d]: got %b, expected 1", p, cmd_ready); end
            cmd_valid = 1'b1; cmd_dst = 4'(dst); cmd_len = 8'(len);
            wr_valid = 1'b0; in_ack = 1'($urandom_range(0, 1));
            tick();
            cmd_valid = 1'b0;
            cyc = 0;
            while (pkt_done !== 1'b1 && cyc < 300) begin
                in_ack   = ($urandom_range(0, 3) != 0);
                wr_valid = 1'($urandom_range(0, 1));
                wr_data  = $urandom;
                prev_req = out_req; prev_ack = in_ack; prev_flit = out_flit;
                tick();
                cyc++;
                if (prev_req && !prev_ack) begin
                    n_vec++; if (out_req !== 1'b1 || out_flit !== prev_flit) begin n_err++; $display("FAIL rnd_hold[%0d]: got %h req %b, expected %h req 1", p, out_flit, out_req, prev_flit); end
                end
            end
            wr_valid = 1'b0;
            n_vec++; if (pkt_done !== 1'b1) begin n_err++; $display("FAIL rnd_done_timeout[%0d]: got %b, expected 1", p, pkt_done); end
            exp_count++;
            n_vec++; if (pkt_count !== 16'(exp_count)) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d, expected %0d", p, pkt_count, exp_count); end
            expect_packet(dst, len);
            n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_flit_count[%0d]: got %0d, expected %0d", p, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_flit[%0d.%0d]: got %h, expected %h", p, i, got_q[i], exp_q[i]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        wr_valid = 1'b1; wr_data = $urandom; tick();
        wr_valid = 1'b0;
        in_ack = 1'b0;
        cmd_valid = 1'b1; cmd_dst = 4'd1; cmd_len = 8'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_vec++; if (out_req !== 1'b1) begin n_err++; $display("FAIL mid_pre_req: got %b, expected 1", out_req); end
        rst = 1'b1;
        tick();
        n_vec++; if (out_req !== 1'b0)    begin n_err++; $display("FAIL mid_rst_req: got %b, expected 0", out_req); end
        n_vec++; if (out_flit !== 34'h0)  begin n_err++; $display("FAIL mid_rst_flit: got %h, expected 0", out_flit); end
        n_vec++; if (pkt_count !== 16'h0) begin n_err++; $display("FAIL mid_rst_count: got %0d, expected 0", pkt_count); end
        n_vec++; if (cmd_ready !== 1'b1)  begin n_err++; $display("FAIL mid_rst_cmd_ready: got %b, expected 1", cmd_ready); end
        rst = 1'b0;
        model_q.delete();
        exp_count = 0;
        w = $urandom;
        wr_valid = 1'b1; wr_data = w; tick();
        wr_valid = 1'b0;
        got_q.delete();
        in_ack = 1'b1;
        cmd_valid = 1'b1; cmd_dst = 4'd5; cmd_len = 8'd1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        n_vec++; if (pkt_done !== 1'b1) begin n_err++; $display("FAIL mid_after_done: got %b, expected 1", pkt_done); end
        n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL mid_after_count: got %0d flits, expected 2", got_q.size()); end
        else if (got_q[1] !== body_flit(w, 1'b1)) begin n_err++; $display("FAIL mid_flushed_word: got %h, expected %h", got_q[1], body_flit(w, 1'b1)); end
        tick();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_dst = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; in_ack = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_len2();
        test_backpressure();
        test_starvation();
        test_fifo_full();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
